// File: rtl/apb_periph_hub_pkg.sv
// Shared types and constants for the APB peripheral hub: FSM states,
// local register offsets and STATUS bit positions.
package apb_periph_hub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // idx_t is sized for the largest hub (16 slaves + local window + one decode-error value).
    localparam int unsigned MaxSlaves = 16;
    typedef logic [$clog2(MaxSlaves + 2)-1:0] idx_t;

    localparam logic [1:0] REG_STATUS      = 2'd0;
    localparam logic [1:0] REG_LAST_ERR    = 2'd1;
    localparam logic [1:0] REG_TIMEOUT_CNT = 2'd2;
    localparam logic [1:0] REG_ID          = 2'd3;

    localparam int unsigned STATUS_DECERR  = 0;
    localparam int unsigned STATUS_TIMEOUT = 1;
    localparam int unsigned STATUS_SLVERR  = 2;

endpackage

// File: rtl/apb_periph_hub_regs.sv
// Local diagnostic register window: sticky W1C STATUS, last error address,
// saturating timeout counter and a read-only ID.
module apb_periph_hub_regs
    import apb_periph_hub_pkg::*;
#(
    parameter int unsigned NrSlaves      = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned SlaveAddrBits = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     acc_i,
    input  logic                     write_i,
    input  logic [SlaveAddrBits-3:0] word_i,
    input  logic [2:0]               w1c_i,
    input  logic                     ev_decerr_i,
    input  logic                     ev_timeout_i,
    input  logic                     ev_slverr_i,
    input  logic [AddrWidth-1:0]     err_addr_i,
    output logic [DataWidth-1:0]     rdata_o,
    output logic                     irq_o
);

    logic [2:0]           status_q, status_d;
    logic [AddrWidth-1:0] last_err_q, last_err_d;
    logic [DataWidth-1:0] tocnt_q, tocnt_d;
    logic                 word_valid;
    logic [1:0]           word_sel;

    // Only the first four words are backed; anything beyond reads 0 and ignores writes.
    assign word_valid = (word_i >> 2) == '0;
    assign word_sel   = word_i[1:0];

    always_comb begin
        status_d   = status_q;
        last_err_d = last_err_q;
        tocnt_d    = tocnt_q;

        if (acc_i && write_i && word_valid) begin
            unique case (word_sel)
                REG_STATUS:      status_d = status_q & ~w1c_i;
                REG_TIMEOUT_CNT: tocnt_d  = '0;
                default: ;
            endcase
        end

        // Set events are applied after the clear so they always win.
        if (ev_decerr_i)  status_d[STATUS_DECERR]  = 1'b1;
        if (ev_timeout_i) status_d[STATUS_TIMEOUT] = 1'b1;
        if (ev_slverr_i)  status_d[STATUS_SLVERR]  = 1'b1;

        if (ev_decerr_i || ev_timeout_i || ev_slverr_i) begin
            last_err_d = err_addr_i;
        end
        if (ev_timeout_i && (tocnt_q != '1)) begin
            tocnt_d = tocnt_q + 1'b1;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (word_valid) begin
            unique case (word_sel)
                REG_STATUS:      rdata_o = DataWidth'(status_q);
                REG_LAST_ERR:    rdata_o = DataWidth'(last_err_q);
                REG_TIMEOUT_CNT: rdata_o = tocnt_q;
                REG_ID:          rdata_o = DataWidth'(NrSlaves);
                default:         rdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_q   <= '0;
            last_err_q <= '0;
            tocnt_q    <= '0;
        end else begin
            status_q   <= status_d;
            last_err_q <= last_err_d;
            tocnt_q    <= tocnt_d;
        end
    end

    assign irq_o = |status_q;

endmodule

// File: rtl/apb_periph_hub.sv
// APB fan-out hub: window decode, registered setup/access to one of NrSlaves
// downstream slaves, PREADY timeout watchdog and a local status window.
module apb_periph_hub
    import apb_periph_hub_pkg::*;
#(
    parameter int unsigned          NrSlaves      = 4,
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          SlaveAddrBits = 12,
    parameter logic [AddrWidth-1:0] BaseAddr      = 32'hC000_0000,
    parameter int unsigned          TimeoutCycles = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            psel_i,
    input  logic                            penable_i,
    input  logic                            pwrite_i,
    input  logic [AddrWidth-1:0]            paddr_i,
    input  logic [DataWidth-1:0]            pwdata_i,
    output logic [DataWidth-1:0]            prdata_o,
    output logic                            pready_o,
    output logic                            pslverr_o,
    output logic [NrSlaves-1:0]             psel_o,
    output logic                            penable_o,
    output logic                            pwrite_o,
    output logic [SlaveAddrBits-1:0]        paddr_o,
    output logic [DataWidth-1:0]            pwdata_o,
    input  logic [NrSlaves*DataWidth-1:0]   prdata_i,
    input  logic [NrSlaves-1:0]             pready_i,
    input  logic [NrSlaves-1:0]             pslverr_i,
    output logic                            irq_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles);

    state_e                state_q, state_d;
    logic [NrSlaves-1:0]   psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DataWidth-1:0]  prdata_q, prdata_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;
    logic                  write_q, write_d;
    idx_t                  idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic [AddrWidth-1:0]  idx_full;
    logic                  is_slave, is_local, setup;
    logic                  sel_rdy, sel_err;
    logic [DataWidth-1:0]  sel_rdata;
    logic                  reg_acc, ev_dec, ev_to, ev_slv;
    logic [AddrWidth-1:0]  err_addr;
    logic [DataWidth-1:0]  reg_rdata;

    // Full-width subtract: addresses below BaseAddr wrap to a huge index.
    assign idx_full = (paddr_i - BaseAddr) >> SlaveAddrBits;
    assign is_slave = idx_full < AddrWidth'(NrSlaves);
    assign is_local = idx_full == AddrWidth'(NrSlaves);
    assign setup    = psel_i & ~penable_i;

    always_comb begin
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NrSlaves; i++) begin
            if (idx_q == idx_t'(i)) begin
                sel_rdy   = pready_i[i];
                sel_err   = pslverr_i[i];
                sel_rdata = prdata_i[i*DataWidth +: DataWidth];
            end
        end
    end

    apb_periph_hub_regs #(
        .NrSlaves      (NrSlaves),
        .AddrWidth     (AddrWidth),
        .DataWidth     (DataWidth),
        .SlaveAddrBits (SlaveAddrBits)
    ) u_regs (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .acc_i        (reg_acc),
        .write_i      (pwrite_i),
        .word_i       (paddr_i[SlaveAddrBits-1:2]),
        .w1c_i        (pwdata_i[2:0]),
        .ev_decerr_i  (ev_dec),
        .ev_timeout_i (ev_to),
        .ev_slverr_i  (ev_slv),
        .err_addr_i   (err_addr),
        .rdata_o      (reg_rdata),
        .irq_o        (irq_o)
    );

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        reg_acc   = 1'b0;
        ev_dec    = 1'b0;
        ev_to     = 1'b0;
        ev_slv    = 1'b0;
        err_addr  = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    addr_d   = paddr_i;
                    wdata_d  = pwdata_i;
                    write_d  = pwrite_i;
                    idx_d    = idx_t'(idx_full);
                    err_addr = paddr_i;
                    if (is_slave) begin
                        state_d = ST_SETUP;
                        for (int unsigned i = 0; i < NrSlaves; i++) begin
                            psel_d[i] = (idx_full == AddrWidth'(i));
                        end
                    end else begin
                        // Local and decode-error accesses answer without wait states.
                        state_d  = ST_RESP;
                        pready_d = 1'b1;
                        if (is_local) begin
                            reg_acc = 1'b1;
                            if (!pwrite_i) prdata_d = reg_rdata;
                        end else begin
                            ev_dec    = 1'b1;
                            pslverr_d = 1'b1;
                        end
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sel_rdy) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = sel_err;
                    ev_slv    = sel_err;
                    if (!write_q) prdata_d = sel_rdata;
                    state_d   = ST_RESP;
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    ev_to     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = write_q;
    assign paddr_o   = addr_q[SlaveAddrBits-1:0];
    assign pwdata_o  = wdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_periph_hub.sv
// Scoreboard bench for apb_periph_hub: a behavioural address-map / register
// model predicts each response; a negedge monitor checks the DUT against it.
module tb_apb_periph_hub;

    localparam int unsigned NS   = 4;
    localparam int unsigned TO   = 16;
    localparam logic [31:0] BASE = 32'hC000_0000;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              psel_i, penable_i, pwrite_i;
    logic [31:0]       paddr_i, pwdata_i;
    logic [31:0]       prdata_o;
    logic              pready_o, pslverr_o;
    logic [NS-1:0]     psel_o;
    logic              penable_o, pwrite_o;
    logic [11:0]       paddr_o;
    logic [31:0]       pwdata_o;
    logic [NS*32-1:0]  prdata_i;
    logic [NS-1:0]     pready_i, pslverr_i;
    logic              irq_o;

    apb_periph_hub #(
        .NrSlaves      (NS),
        .AddrWidth     (32),
        .DataWidth     (32),
        .SlaveAddrBits (12),
        .BaseAddr      (BASE),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwrite_i  (pwrite_i),
        .paddr_i   (paddr_i),
        .pwdata_i  (pwdata_i),
        .prdata_o  (prdata_o),
        .pready_o  (pready_o),
        .pslverr_o (pslverr_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural slaves: slave i raises pready after wait_cfg[i] ACCESS cycles.
    int          wait_cfg [NS];
    logic [31:0] slv_data [NS];
    logic        slv_err  [NS];
    int          acc_cnt;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                     acc_cnt <= 0;
        else if (|psel_o && penable_o) acc_cnt <= acc_cnt + 1;
        else                           acc_cnt <= 0;
    end

    always_comb begin
        pready_i  = '0;
        pslverr_i = '0;
        prdata_i  = '0;
        for (int i = 0; i < NS; i++) begin
            pready_i[i]          = psel_o[i] && penable_o && (acc_cnt == wait_cfg[i]);
            pslverr_i[i]         = slv_err[i];
            prdata_i[i*32 +: 32] = slv_data[i];
        end
    end

    // Reference model of the hub's register state.
    logic [2:0]  m_status;
    logic [31:0] m_last_err;
    logic [31:0] m_tocnt;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        logic        irq;
    } exp_t;
    exp_t sb[$];

    // Expected downstream activity window for the current slave access.
    logic          ds_active = 1'b0;
    int unsigned   ds_t, ds_lat;
    logic [NS-1:0] ds_sel;
    logic [11:0]   ds_addr;
    logic [31:0]   ds_wd;
    logic          ds_wr;
    logic          started = 1'b0;

    task automatic model(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         output int unsigned lat, output logic [31:0] data, output logic err,
                         output logic chkd, output logic is_slv, output int unsigned idx);
        logic [31:0] diff;
        logic [31:0] off;
        diff   = addr - BASE;
        idx    = diff / 4096;
        off    = diff % 4096;
        is_slv = 1'b0;
        data   = '0;
        err    = 1'b0;
        chkd   = 1'b1;
        if (idx < NS) begin
            is_slv = 1'b1;
            if (wait_cfg[idx] >= TO) begin
                lat = 2 + TO;
                err = 1'b1;
                m_status[1] = 1'b1;
                if (m_tocnt != 32'hFFFF_FFFF) m_tocnt = m_tocnt + 1;
                m_last_err = addr;
            end else begin
                lat  = 3 + wait_cfg[idx];
                err  = slv_err[idx];
                data = slv_data[idx];
                chkd = !wr;
                if (err) begin
                    m_status[2] = 1'b1;
                    m_last_err  = addr;
                end
            end
        end else if (idx == NS) begin
            lat  = 1;
            chkd = !wr;
            if (off < 16) begin
                case (off / 4)
                    0: data = {29'd0, m_status};
                    1: data = m_last_err;
                    2: data = m_tocnt;
                    default: data = NS;
                endcase
                if (wr && off / 4 == 0) m_status = m_status & ~wd[2:0];
                if (wr && off / 4 == 2) m_tocnt  = 0;
            end
        end else begin
            lat = 1;
            err = 1'b1;
            m_status[0] = 1'b1;
            m_last_err  = addr;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the bus idle.
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        int unsigned lat, idx, n;
        logic [31:0] data;
        logic        err, chkd, is_slv;
        exp_t        e;
        model(addr, wr, wd, lat, data, err, chkd, is_slv, idx);
        e.cyc = cyc + lat; e.data = data; e.err = err; e.chk_data = chkd; e.irq = |m_status;
        sb.push_back(e);
        ds_active = is_slv;
        ds_t      = cyc;
        ds_lat    = lat;
        ds_sel    = NS'(1) << idx;
        ds_addr   = addr[11:0];
        ds_wd     = wd;
        ds_wr     = wr;
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwrite_i = wr; pwdata_i = wd;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        n = 0;
        while (!pready_o && n < 60) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!pready_o) begin
            n_checks++; n_fail++;
            $display("FAIL xfer_timeout: no pready_o for addr %h within 60 cycles", addr);
        end
        @(posedge clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    always @(negedge clk_i) begin : monitor
        exp_t          e;
        logic [NS-1:0] exp_sel;
        if (!rst_i && started) begin
            if (pready_o) begin
                if (sb.size() == 0) begin
                    chk("pready_unexpected", {31'd0, pready_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("pslverr", {31'd0, pslverr_o}, {31'd0, e.err});
                    if (e.chk_data) chk("prdata", prdata_o, e.data);
                    chk("irq", {31'd0, irq_o}, {31'd0, e.irq});
                end
            end else begin
                chk("prdata_idle", prdata_o, 32'd0);
            end
            exp_sel = (ds_active && cyc > ds_t && cyc < ds_t + ds_lat) ? ds_sel : '0;
            chk("psel", {28'd0, psel_o}, {28'd0, exp_sel});
            chk("penable", {31'd0, penable_o}, {31'd0, (exp_sel != '0) && (cyc >= ds_t + 2)});
            if (exp_sel != '0) begin
                chk("paddr", {20'd0, paddr_o}, {20'd0, ds_addr});
                chk("pwdata", pwdata_o, ds_wd);
                chk("pwrite", {31'd0, pwrite_o}, {31'd0, ds_wr});
            end
        end
    end

    initial begin
        int unsigned kind, s, t0;
        logic [31:0] a;
        rst_i = 1'b1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0; pwdata_i = '0;
        m_status = '0; m_last_err = '0; m_tocnt = '0;
        for (int i = 0; i < NS; i++) begin
            wait_cfg[i] = 0; slv_data[i] = $urandom; slv_err[i] = 1'b0;
        end
        #12;
        chk("rst_psel", {28'd0, psel_o}, 32'd0);
        chk("rst_penable", {31'd0, penable_o}, 32'd0);
        chk("rst_pready", {31'd0, pready_o}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr_o}, 32'd0);
        chk("rst_prdata", prdata_o, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i); #1 rst_i = 1'b0;
        started = 1'b1;
        @(posedge clk_i); #1;

        slv_data[1] = 32'hA5A5_0001; wait_cfg[1] = 0;
        apb_xfer(32'hC000_1004, 1'b0, 32'h0);
        wait_cfg[3] = 5;
        apb_xfer(32'hC000_3010, 1'b1, 32'h0000_1234);
        apb_xfer(32'hC000_5000, 1'b0, 32'h0);
        apb_xfer(32'hC000_4000, 1'b0, 32'h0);
        apb_xfer(32'hC000_4004, 1'b0, 32'h0);
        apb_xfer(32'hC000_4000, 1'b1, 32'h1);
        wait_cfg[0] = 100;
        apb_xfer(32'hC000_0ABC, 1'b0, 32'h0);
        apb_xfer(32'hC000_4008, 1'b0, 32'h0);
        apb_xfer(32'hC000_4000, 1'b0, 32'h0);
        apb_xfer(32'hC000_4000, 1'b1, 32'h2);
        wait_cfg[0] = TO - 1;
        apb_xfer(32'hC000_0010, 1'b0, 32'h0);
        slv_err[2] = 1'b1; wait_cfg[2] = 2;
        apb_xfer(32'hC000_2FFC, 1'b1, 32'hDEAD_BEEF);
        slv_err[2] = 1'b0;
        apb_xfer(32'h0000_1000, 1'b0, 32'h0);
        apb_xfer(32'hC000_4000, 1'b0, 32'h0);
        apb_xfer(32'hC000_4004, 1'b0, 32'h0);
        apb_xfer(32'hC000_4010, 1'b1, 32'hFFFF_FFFF);
        apb_xfer(32'hC000_4010, 1'b0, 32'h0);
        apb_xfer(32'hC000_400C, 1'b0, 32'h0);
        apb_xfer(32'hC000_4008, 1'b1, 32'h0);
        apb_xfer(32'hC000_4008, 1'b0, 32'h0);
        apb_xfer(32'hC000_4000, 1'b1, 32'h7);
        apb_xfer(32'hC000_4000, 1'b0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                s = $urandom_range(0, NS - 1);
                a = BASE + s * 4096 + $urandom_range(0, 1023) * 4;
                wait_cfg[s] = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 4);
                slv_err[s]  = ($urandom_range(0, 3) == 0);
                slv_data[s] = $urandom;
            end else if (kind < 8) begin
                a = BASE + 32'h4000 + $urandom_range(0, 7) * 4;
            end else if (kind == 8) begin
                a = BASE + (5 + $urandom_range(0, 100)) * 4096;
            end else begin
                a = $urandom_range(0, 32'hBFFF_FFFF);
            end
            apb_xfer(a, 1'($urandom_range(0, 1)), $urandom);
        end

        // Asynchronous reset in the middle of a slave access.
        apb_xfer(32'hC000_7000, 1'b0, 32'h0);
        wait_cfg[2] = 10;
        t0 = cyc;
        ds_active = 1'b1; ds_t = t0; ds_lat = 5; ds_sel = 4'b0100;
        ds_addr = 12'h008; ds_wd = 32'h0; ds_wr = 1'b0;
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'hC000_2008; pwrite_i = 1'b0; pwdata_i = '0;
        @(posedge clk_i); #1 penable_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1 rst_i = 1'b1;
        #1;
        chk("async_rst_psel", {28'd0, psel_o}, 32'd0);
        chk("async_rst_penable", {31'd0, penable_o}, 32'd0);
        chk("async_rst_pready", {31'd0, pready_o}, 32'd0);
        chk("async_rst_irq", {31'd0, irq_o}, 32'd0);
        m_status = '0; m_last_err = '0; m_tocnt = '0;
        sb.delete();
        ds_active = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i); #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        wait_cfg[2] = 1;
        apb_xfer(32'hC000_2008, 1'b0, 32'h0);
        apb_xfer(32'hC000_4000, 1'b0, 32'h0);
        apb_xfer(32'hC000_4008, 1'b0, 32'h0);

        repeat (3) @(posedge clk_i);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
